// File: rtl/apb_master_seq.sv
// APB initiator: turns one command into one SETUP/ACCESS transfer and returns a one-cycle response.
// Optional ACCESS-phase timeout abort is enabled with `define APB_MASTER_TIMEOUT_EN.
module apb_master_seq #(
    parameter int unsigned DW          = 8,
    parameter int unsigned BW          = 32,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MAX_DIM     = BW / DW,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_write_i,
    input  logic [ADDR_W-1:0]  cmd_addr_i,
    input  logic [BW-1:0]      cmd_wdata_i,
    input  logic [MAX_DIM-1:0] cmd_strb_i,
    output logic               rsp_valid_o,
    output logic [BW-1:0]      rsp_rdata_o,
    output logic               rsp_err_o,
    output logic               rsp_timeout_o,
    output logic               busy_o,
    output logic               psel_o,
    output logic               penable_o,
    output logic               pwrite_o,
    output logic [ADDR_W-1:0]  paddr_o,
    output logic [BW-1:0]      pwdata_o,
    output logic [MAX_DIM-1:0] pstrb_o,
    input  logic [BW-1:0]      prdata_i,
    input  logic               pready_i,
    input  logic               pslverr_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [BW-1:0]      pwdata_q, pwdata_d;
    logic [MAX_DIM-1:0] pstrb_q, pstrb_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [BW-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
    logic               rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`else
    logic [CNT_W-1:0]   unused_cnt;
    assign unused_cnt = '0;
`endif

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
`endif
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        busy_d        = busy_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = cmd_write_i;
                    paddr_d     = cmd_addr_i;
                    pwdata_d    = cmd_write_i ? cmd_wdata_i : '0;
                    pstrb_d     = cmd_write_i ? cmd_strb_i : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d       = IDLE;
                    cmd_ready_d   = 1'b1;
                    busy_d        = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
                    rsp_err_d     = pslverr_i;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Count would reach the limit at this edge: abort
                    state_d       = IDLE;
                    cmd_ready_d   = 1'b1;
                    busy_d        = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d         = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign busy_o        = busy_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_timeout_o = rsp_timeout_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_seq.sv
// Randomized self-checking bench for apb_master_seq with a transaction-level APB slave/response model.
module tb_apb_master_seq;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [15:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_strb_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        busy_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [15:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    int n_chk = 0;
    int n_err = 0;

    apb_master_seq dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .cmd_strb_i   (cmd_strb_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .busy_o       (busy_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .pstrb_o      (pstrb_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i),
        .pslverr_i    (pslverr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string ph, input logic [15:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
        chk({ph, "_addr"},  64'(paddr_o),  64'(a));
        chk({ph, "_write"}, 64'(pwrite_o), 64'(w));
        chk({ph, "_wdata"}, 64'(pwdata_o), 64'(d));
        chk({ph, "_strb"},  64'(pstrb_o),  64'(s));
    endtask

    task automatic present(input logic wr, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        cmd_strb_i  = s;
    endtask

    task automatic scramble_cmd();
        cmd_write_i = 1'($urandom);
        cmd_addr_i  = 16'($urandom);
        cmd_wdata_i = $urandom;
        cmd_strb_i  = 4'($urandom);
    endtask

    // One complete transfer; expectations come from the transaction, not from DUT state
    task automatic do_xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int waits, input logic err,
                           input logic [31:0] rd);
        logic [31:0] ew;
        logic [3:0]  es;
        logic [31:0] erd;
        ew  = wr ? d : 32'h0;
        es  = wr ? s : 4'h0;
        erd = wr ? 32'h0 : rd;
        chk("idle_ready", 64'(cmd_ready_o), 64'(1));
        chk("idle_busy",  64'(busy_o),      64'(0));
        present(wr, a, d, s);
        pready_i  = 1'($urandom);
        pslverr_i = 1'($urandom);
        step();
        cmd_valid_i = 1'($urandom);
        scramble_cmd();
        chk("setup_psel",    64'(psel_o),      64'(1));
        chk("setup_penable", 64'(penable_o),   64'(0));
        chk("setup_ready",   64'(cmd_ready_o), 64'(0));
        chk("setup_busy",    64'(busy_o),      64'(1));
        chk("setup_rsp",     64'(rsp_valid_o), 64'(0));
        chk_bus("setup", a, wr, ew, es);
        pready_i  = 1'($urandom);
        pslverr_i = 1'($urandom);
        step();
        for (int k = 0; k <= waits; k++) begin
            chk("acc_psel",    64'(psel_o),      64'(1));
            chk("acc_penable", 64'(penable_o),   64'(1));
            chk("acc_busy",    64'(busy_o),      64'(1));
            chk("acc_rsp",     64'(rsp_valid_o), 64'(0));
            chk_bus("acc", a, wr, ew, es);
            pready_i    = (k == waits);
            pslverr_i   = (k == waits) ? err : 1'($urandom);
            prdata_i    = (k == waits) ? rd : $urandom;
            cmd_valid_i = (k == waits) ? 1'b0 : 1'($urandom);
            scramble_cmd();
            step();
        end
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = $urandom;
        chk("end_psel",    64'(psel_o),        64'(0));
        chk("end_penable", 64'(penable_o),     64'(0));
        chk("end_rsp",     64'(rsp_valid_o),   64'(1));
        chk("end_rdata",   64'(rsp_rdata_o),   64'(erd));
        chk("end_err",     64'(rsp_err_o),     64'(err));
        chk("end_tmo",     64'(rsp_timeout_o), 64'(0));
        chk("end_busy",    64'(busy_o),        64'(0));
        chk("end_ready",   64'(cmd_ready_o),   64'(1));
        step();
        chk("post_rsp",   64'(rsp_valid_o), 64'(0));
        chk("hold_rdata", 64'(rsp_rdata_o), 64'(erd));
        chk("hold_err",   64'(rsp_err_o),   64'(err));
    endtask

    task automatic stall_test();
        int n;
        present(1'b0, 16'h0020, 32'h0, 4'h0);
        pready_i = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        step();
        n = 0;
`ifdef APB_MASTER_TIMEOUT_EN
        prdata_i = 32'hDEADBEEF;
        while (psel_o && n < 200) begin
            n++;
            step();
        end
        chk("tmo_cycles",  64'(n),             64'(TMO));
        chk("tmo_psel",    64'(psel_o),        64'(0));
        chk("tmo_rsp",     64'(rsp_valid_o),   64'(1));
        chk("tmo_err",     64'(rsp_err_o),     64'(1));
        chk("tmo_flag",    64'(rsp_timeout_o), 64'(1));
        chk("tmo_rdata",   64'(rsp_rdata_o),   64'(0));
        chk("tmo_ready",   64'(cmd_ready_o),   64'(1));
`else
        for (int c = 0; c < 120; c++) begin
            if (psel_o && penable_o) n++;
            step();
        end
        chk("stall_cycles", 64'(n), 64'(120));
        prdata_i = 32'h5A5A0001;
        pready_i = 1'b1;
        step();
        pready_i = 1'b0;
        chk("stall_rsp",   64'(rsp_valid_o),   64'(1));
        chk("stall_rdata", 64'(rsp_rdata_o),   64'(32'h5A5A0001));
        chk("stall_tmo",   64'(rsp_timeout_o), 64'(0));
`endif
        step();
    endtask

    task automatic reset_mid_test();
        present(1'b1, 16'h0040, 32'hCAFEF00D, 4'hF);
        pready_i = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        step();
        step();
        chk("rst_pre_psel", 64'(psel_o), 64'(1));
        reset_i  = 1'b1;
        pready_i = 1'b1;
        step();
        chk("rst_psel",    64'(psel_o),      64'(0));
        chk("rst_penable", 64'(penable_o),   64'(0));
        chk("rst_busy",    64'(busy_o),      64'(0));
        chk("rst_ready",   64'(cmd_ready_o), 64'(1));
        chk("rst_rsp",     64'(rsp_valid_o), 64'(0));
        reset_i = 1'b0;
        step();
        chk("rst_rsp2",  64'(rsp_valid_o), 64'(0));
        chk("rst_psel2", 64'(psel_o),      64'(0));
        pready_i = 1'b0;
    endtask

    task automatic b2b_test();
        logic [15:0] addrs[3];
        int acc_cyc[$];
        int rsp_cyc[$];
        logic [31:0] rsp_dat[$];
        int idx;
        for (int i = 0; i < 3; i++) addrs[i] = 16'($urandom);
        idx       = 0;
        pready_i  = 1'b1;
        pslverr_i = 1'b0;
        for (int c = 0; c < 14; c++) begin
            prdata_i = {16'hA5A5, paddr_o};
            if (rsp_valid_o) begin
                rsp_cyc.push_back(c);
                rsp_dat.push_back(rsp_rdata_o);
            end
            if (idx < 3) present(1'b0, addrs[idx], 32'h0, 4'h0);
            else cmd_valid_i = 1'b0;
            if (cmd_valid_i && cmd_ready_o) begin
                acc_cyc.push_back(c);
                idx++;
            end
            step();
        end
        pready_i = 1'b0;
        chk("b2b_nacc", 64'(acc_cyc.size()), 64'(3));
        chk("b2b_nrsp", 64'(rsp_cyc.size()), 64'(3));
        for (int i = 0; i < acc_cyc.size() && i < 3; i++)
            chk("b2b_acc_cyc", 64'(acc_cyc[i]), 64'(3 * i));
        for (int i = 0; i < rsp_cyc.size() && i < 3; i++) begin
            chk("b2b_rsp_cyc",  64'(rsp_cyc[i]), 64'(3 * i + 3));
            chk("b2b_rsp_data", 64'(rsp_dat[i]), 64'({16'hA5A5, addrs[i]}));
        end
    endtask

    initial begin
        reset_i     = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        cmd_strb_i  = '0;
        prdata_i    = '0;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;
        step();
        step();
        chk("rst_cmd_ready", 64'(cmd_ready_o),   64'(1));
        chk("rst_psel",      64'(psel_o),        64'(0));
        chk("rst_penable",   64'(penable_o),     64'(0));
        chk("rst_busy",      64'(busy_o),        64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid_o),   64'(0));
        chk("rst_rdata",     64'(rsp_rdata_o),   64'(0));
        chk("rst_err",       64'(rsp_err_o),     64'(0));
        chk("rst_tmo",       64'(rsp_timeout_o), 64'(0));
        chk("rst_bus_addr",  64'(paddr_o),       64'(0));
        chk("rst_bus_wdata", 64'(pwdata_o),      64'(0));
        chk("rst_bus_strb",  64'(pstrb_o),       64'(0));
        chk("rst_bus_write", 64'(pwrite_o),      64'(0));
        reset_i = 1'b0;
        step();

        do_xfer(1'b1, 16'h0004, 32'h01020304, 4'hF, 1, 1'b0, 32'h0);
        do_xfer(1'b0, 16'h000C, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 32'h0000000A);
        do_xfer(1'b1, 16'h0000, 32'h11223344, 4'h3, 0, 1'b1, 32'h0);
        do_xfer(1'b0, 16'h0010, 32'h0, 4'h0, TMO - 1, 1'b0, 32'h00C0FFEE);

        for (int t = 0; t < 40; t++)
            do_xfer(1'($urandom), 16'($urandom), $urandom, 4'($urandom),
                    int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0), $urandom);

        stall_test();
        reset_mid_test();
        b2b_test();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
